// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, op encoding,
// register indices, mstatus/mtags bit positions and per-register write masks.
package csr_pkg;

  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MTAGS     = 12'h7C0;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_op_e;

  typedef enum logic [4:0] {
    REG_NONE,
    REG_MVENDORID,
    REG_MHARTID,
    REG_MSTATUS,
    REG_MISA,
    REG_MIE,
    REG_MTVEC,
    REG_MSCRATCH,
    REG_MEPC,
    REG_MCAUSE,
    REG_MTVAL,
    REG_MIP,
    REG_MTAGS,
    REG_MCYCLE,
    REG_MINSTRET,
    REG_MCYCLEH,
    REG_MINSTRETH
  } csr_reg_e;

  typedef enum logic {
    ST_IDLE,
    ST_EXEC
  } csr_state_e;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  localparam int unsigned MTAGS_EN      = 0;
  localparam int unsigned MTAGS_IRQ_CLR = 1;
  localparam int unsigned MTAGS_IF_EN   = 2;

  localparam logic [63:0] WMASK_NONE    = '0;
  localparam logic [63:0] WMASK_FULL    = '1;
  localparam logic [63:0] WMASK_MSTATUS = 64'h88;
  localparam logic [63:0] WMASK_MIE     = 64'h888;
  localparam logic [63:0] WMASK_MTVEC   = ~64'h3;
  localparam logic [63:0] WMASK_MEPC    = ~64'h1;
  localparam logic [63:0] WMASK_MTAGS   = 64'h7;

  function automatic csr_reg_e csr_decode(input logic [11:0] addr);
    csr_reg_e idx;
    case (addr)
      CSR_MVENDORID: idx = REG_MVENDORID;
      CSR_MHARTID:   idx = REG_MHARTID;
      CSR_MSTATUS:   idx = REG_MSTATUS;
      CSR_MISA:      idx = REG_MISA;
      CSR_MIE:       idx = REG_MIE;
      CSR_MTVEC:     idx = REG_MTVEC;
      CSR_MSCRATCH:  idx = REG_MSCRATCH;
      CSR_MEPC:      idx = REG_MEPC;
      CSR_MCAUSE:    idx = REG_MCAUSE;
      CSR_MTVAL:     idx = REG_MTVAL;
      CSR_MIP:       idx = REG_MIP;
      CSR_MTAGS:     idx = REG_MTAGS;
      CSR_MCYCLE:    idx = REG_MCYCLE;
      CSR_MINSTRET:  idx = REG_MINSTRET;
      CSR_MCYCLEH:   idx = REG_MCYCLEH;
      CSR_MINSTRETH: idx = REG_MINSTRETH;
      default:       idx = REG_NONE;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter built from two 32-bit halves; a write to a half overrides
// that half's increment, and a write to the high half swallows the carry.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_lo_i,
  input  logic [31:0] wdata_hi_i,
  output logic [63:0] value_o
);

  logic [31:0] lo_q;
  logic [31:0] hi_q;
  logic        carry;

  assign carry = inc_i && !wr_lo_i && (lo_q == '1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      if (wr_lo_i)    lo_q <= wdata_lo_i;
      else if (inc_i) lo_q <= lo_q + 32'd1;
      if (wr_hi_i)    hi_q <= wdata_hi_i;
      else if (carry) hi_q <= hi_q + 32'd1;
    end
  end

  assign value_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file with a two-cycle busy/done access handshake and trap/mret
// state updates. Define CSR_COUNTERS_EN to add the mcycle/minstret counters.
module csr_file
  import csr_pkg::*;
#(
  parameter int unsigned CSR_DATA_WIDTH = 32,
  parameter int unsigned CSR_ADDR_WIDTH = 12,
  parameter logic [63:0] HART_ID        = 64'd0,
  parameter logic [25:0] MISA_EXT       = 26'h100,
  parameter logic [63:0] MTVEC_RESET    = 64'd0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      csr_en_i,
  input  logic [1:0]                csr_op_i,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_addr_i,
  input  logic [CSR_DATA_WIDTH-1:0] csr_data_i,
  output logic [CSR_DATA_WIDTH-1:0] csr_data_o,
  output logic                      csr_busy_o,
  output logic                      csr_done_o,
  output logic                      csr_exists_o,
  output logic                      csr_ro_o,
  output logic                      csr_illegal_o,
  input  logic [CSR_DATA_WIDTH-1:0] irq_pending_i,
  input  logic                      instret_i,
  input  logic                      trap_i,
  input  logic                      mret_i,
  input  logic [CSR_DATA_WIDTH-1:0] trap_pc_i,
  input  logic [CSR_DATA_WIDTH-1:0] trap_cause_i,
  input  logic [CSR_DATA_WIDTH-1:0] trap_val_i,
  output logic                      irq_en_o,
  output logic                      tags_en_o,
  output logic                      tags_if_en_o,
  output logic                      tags_irq_clear_o,
  output logic [CSR_DATA_WIDTH-1:0] mtvec_o,
  output logic [CSR_DATA_WIDTH-1:0] mepc_o
);

  localparam int unsigned W = CSR_DATA_WIDTH;

  csr_state_e              state_q, state_d;
  logic                    exec;
  csr_op_e                 op_q;
  logic [CSR_ADDR_WIDTH-1:0] addr_q;
  logic [W-1:0]            wdata_q;
  logic [11:0]             addr12;

  csr_reg_e                reg_idx;
  logic                    exists, ro_viol, wr_en;
  logic [W-1:0]            old_val, new_val, wmask, wval, misa_val;

  logic [W-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic         mstatus_mie_q, mstatus_mpie_q;
  logic         tags_en_q, tags_if_en_q, tags_clr_q;

  logic [W-1:0] data_q;
  logic         done_q, exists_q, ro_q, illegal_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (csr_en_i) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    exec       = (state_q == ST_EXEC);
    csr_busy_o = (state_q == ST_EXEC);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q    <= CSR_OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == ST_IDLE && csr_en_i) begin
      op_q    <= csr_op_e'(csr_op_i);
      addr_q  <= csr_addr_i;
      wdata_q <= csr_data_i;
    end
  end

  assign addr12 = 12'(addr_q);

  // Counter addresses only exist when built in; the high halves only at XLEN=32.
  always_comb begin
    reg_idx = csr_decode(addr12);
`ifndef CSR_COUNTERS_EN
    if (reg_idx inside {REG_MCYCLE, REG_MINSTRET, REG_MCYCLEH, REG_MINSTRETH})
      reg_idx = REG_NONE;
`endif
    if (W == 64 && reg_idx inside {REG_MCYCLEH, REG_MINSTRETH})
      reg_idx = REG_NONE;
  end

  assign exists  = (reg_idx != REG_NONE);
  assign ro_viol = exists && (addr12[11:10] == 2'b11) && (op_q != CSR_OP_READ);
  assign wr_en   = exec && exists && !ro_viol && (op_q != CSR_OP_READ);

  always_comb begin
    misa_val          = '0;
    misa_val[W-1 -: 2] = (W == 64) ? 2'b10 : 2'b01;
    misa_val[25:0]    = MISA_EXT;
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_val, minstret_val, wval64;
  logic [31:0] cnt_wlo, cnt_whi;
  logic        cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;

  assign wval64    = 64'(wval);
  assign cnt_wlo   = wval64[31:0];
  assign cnt_whi   = (W == 64) ? wval64[63:32] : wval64[31:0];
  assign cyc_wr_lo = wr_en && (reg_idx == REG_MCYCLE);
  assign ins_wr_lo = wr_en && (reg_idx == REG_MINSTRET);
  assign cyc_wr_hi = wr_en && ((W == 64) ? (reg_idx == REG_MCYCLE)   : (reg_idx == REG_MCYCLEH));
  assign ins_wr_hi = wr_en && ((W == 64) ? (reg_idx == REG_MINSTRET) : (reg_idx == REG_MINSTRETH));

  csr_counter64 u_mcycle (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc_i      (1'b1),
    .wr_lo_i    (cyc_wr_lo),
    .wr_hi_i    (cyc_wr_hi),
    .wdata_lo_i (cnt_wlo),
    .wdata_hi_i (cnt_whi),
    .value_o    (mcycle_val)
  );

  csr_counter64 u_minstret (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc_i      (instret_i),
    .wr_lo_i    (ins_wr_lo),
    .wr_hi_i    (ins_wr_hi),
    .wdata_lo_i (cnt_wlo),
    .wdata_hi_i (cnt_whi),
    .value_o    (minstret_val)
  );
`else
  logic unused_instret;
  assign unused_instret = instret_i;
`endif

  always_comb begin
    old_val = '0;
    wmask   = WMASK_NONE[W-1:0];
    case (reg_idx)
      REG_MHARTID:  old_val = W'(HART_ID);
      REG_MSTATUS: begin
        old_val[MSTATUS_MIE]  = mstatus_mie_q;
        old_val[MSTATUS_MPIE] = mstatus_mpie_q;
        wmask = WMASK_MSTATUS[W-1:0];
      end
      REG_MISA:     old_val = misa_val;
      REG_MIE:      begin old_val = mie_q;      wmask = WMASK_MIE[W-1:0];   end
      REG_MTVEC:    begin old_val = mtvec_q;    wmask = WMASK_MTVEC[W-1:0]; end
      REG_MSCRATCH: begin old_val = mscratch_q; wmask = WMASK_FULL[W-1:0];  end
      REG_MEPC:     begin old_val = mepc_q;     wmask = WMASK_MEPC[W-1:0];  end
      REG_MCAUSE:   begin old_val = mcause_q;   wmask = WMASK_FULL[W-1:0];  end
      REG_MTVAL:    begin old_val = mtval_q;    wmask = WMASK_FULL[W-1:0];  end
      REG_MIP:      old_val = irq_pending_i;
      REG_MTAGS: begin
        old_val[MTAGS_EN]    = tags_en_q;
        old_val[MTAGS_IF_EN] = tags_if_en_q;
        wmask = WMASK_MTAGS[W-1:0];
      end
`ifdef CSR_COUNTERS_EN
      REG_MCYCLE:    begin old_val = W'(mcycle_val);          wmask = WMASK_FULL[W-1:0]; end
      REG_MINSTRET:  begin old_val = W'(minstret_val);        wmask = WMASK_FULL[W-1:0]; end
      REG_MCYCLEH:   begin old_val = W'(mcycle_val[63:32]);   wmask = WMASK_FULL[W-1:0]; end
      REG_MINSTRETH: begin old_val = W'(minstret_val[63:32]); wmask = WMASK_FULL[W-1:0]; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    case (op_q)
      CSR_OP_WRITE: new_val = wdata_q;
      CSR_OP_SET:   new_val = old_val | wdata_q;
      CSR_OP_CLEAR: new_val = old_val & ~wdata_q;
      default:      new_val = old_val;
    endcase
    wval = new_val & wmask;
  end

  // Trap and mret own the fields they touch; a same-cycle CSR write to them is dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
    end else if (trap_i) begin
      mstatus_mpie_q <= mstatus_mie_q;
      mstatus_mie_q  <= 1'b0;
    end else if (mret_i) begin
      mstatus_mie_q  <= mstatus_mpie_q;
      mstatus_mpie_q <= 1'b1;
    end else if (wr_en && reg_idx == REG_MSTATUS) begin
      mstatus_mie_q  <= wval[MSTATUS_MIE];
      mstatus_mpie_q <= wval[MSTATUS_MPIE];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (trap_i) begin
      mepc_q   <= {trap_pc_i[W-1:1], 1'b0};
      mcause_q <= trap_cause_i;
      mtval_q  <= trap_val_i;
    end else begin
      if (wr_en && reg_idx == REG_MEPC)   mepc_q   <= wval;
      if (wr_en && reg_idx == REG_MCAUSE) mcause_q <= wval;
      if (wr_en && reg_idx == REG_MTVAL)  mtval_q  <= wval;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mie_q        <= '0;
      mtvec_q      <= MTVEC_RESET[W-1:0] & WMASK_MTVEC[W-1:0];
      mscratch_q   <= '0;
      tags_en_q    <= 1'b0;
      tags_if_en_q <= 1'b0;
      tags_clr_q   <= 1'b0;
    end else begin
      if (wr_en && reg_idx == REG_MIE)      mie_q      <= wval;
      if (wr_en && reg_idx == REG_MTVEC)    mtvec_q    <= wval;
      if (wr_en && reg_idx == REG_MSCRATCH) mscratch_q <= wval;
      if (wr_en && reg_idx == REG_MTAGS) begin
        tags_en_q    <= wval[MTAGS_EN];
        tags_if_en_q <= wval[MTAGS_IF_EN];
      end
      tags_clr_q <= wr_en && (reg_idx == REG_MTAGS) && wval[MTAGS_IRQ_CLR];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q    <= '0;
      done_q    <= 1'b0;
      exists_q  <= 1'b0;
      ro_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q <= exec;
      if (exec) begin
        data_q    <= old_val;
        exists_q  <= exists;
        ro_q      <= ro_viol;
        illegal_q <= !exists || ro_viol;
      end
    end
  end

  assign csr_data_o       = data_q;
  assign csr_done_o       = done_q;
  assign csr_exists_o     = exists_q;
  assign csr_ro_o         = ro_q;
  assign csr_illegal_o    = illegal_q;
  assign irq_en_o         = mstatus_mie_q;
  assign tags_en_o        = tags_en_q;
  assign tags_if_en_o     = tags_if_en_q;
  assign tags_irq_clear_o = tags_clr_q;
  assign mtvec_o          = mtvec_q;
  assign mepc_o           = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file (XLEN=32); counter checks follow
// CSR_COUNTERS_EN the same way the design does.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        csr_en = 1'b0;
  logic [1:0]  csr_op = 2'd0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        csr_busy, csr_done, csr_exists, csr_ro, csr_illegal;
  logic [31:0] irq_pending = '0;
  logic        instret = 1'b0;
  logic        trap = 1'b0;
  logic        mret = 1'b0;
  logic [31:0] trap_pc = '0, trap_cause = '0, trap_val = '0;
  logic        irq_en, tags_en, tags_if_en, tags_irq_clear;
  logic [31:0] mtvec, mepc;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] rd_data;
  logic        rd_exists, rd_ro, rd_ill;

  always #5 clk = ~clk;

  csr_file #(
    .CSR_DATA_WIDTH (32),
    .CSR_ADDR_WIDTH (12),
    .HART_ID        (64'h5),
    .MISA_EXT       (26'h100),
    .MTVEC_RESET    (64'h1000)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .csr_en_i         (csr_en),
    .csr_op_i         (csr_op),
    .csr_addr_i       (csr_addr),
    .csr_data_i       (csr_wdata),
    .csr_data_o       (csr_rdata),
    .csr_busy_o       (csr_busy),
    .csr_done_o       (csr_done),
    .csr_exists_o     (csr_exists),
    .csr_ro_o         (csr_ro),
    .csr_illegal_o    (csr_illegal),
    .irq_pending_i    (irq_pending),
    .instret_i        (instret),
    .trap_i           (trap),
    .mret_i           (mret),
    .trap_pc_i        (trap_pc),
    .trap_cause_i     (trap_cause),
    .trap_val_i       (trap_val),
    .irq_en_o         (irq_en),
    .tags_en_o        (tags_en),
    .tags_if_en_o     (tags_if_en),
    .tags_irq_clear_o (tags_irq_clear),
    .mtvec_o          (mtvec),
    .mepc_o           (mepc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called one time unit after a rising edge; returns one time unit into cycle N+2.
  task automatic csr_req(input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] d, input bit with_trap);
    csr_en    = 1'b1;
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = d;
    @(posedge clk); #1;
    csr_en = 1'b0;
    check("busy_n1", csr_busy, 1);
    check("done_n1", csr_done, 0);
    if (with_trap) trap = 1'b1;
    @(posedge clk); #1;
    trap = 1'b0;
    check("busy_n2", csr_busy, 0);
    check("done_n2", csr_done, 1);
    rd_data   = csr_rdata;
    rd_exists = csr_exists;
    rd_ro     = csr_ro;
    rd_ill    = csr_illegal;
  endtask

  task automatic pulse(input bit do_trap, input bit do_mret);
    trap = do_trap;
    mret = do_mret;
    @(posedge clk); #1;
    trap = 1'b0;
    mret = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_busy",  csr_busy, 0);
    check("rst_done",  csr_done, 0);
    check("rst_irqen", irq_en, 0);
    check("rst_mtvec", mtvec, 32'h1000);
    check("rst_mepc",  mepc, 0);
    check("rst_tags",  {tags_en, tags_if_en, tags_irq_clear}, 0);

    csr_req(2'd2, 12'h300, 32'h8, 0);
    check("set_mst_old", rd_data, 0);
    check("set_mst_irq", irq_en, 1);
    csr_req(2'd3, 12'h300, 32'h8, 0);
    check("clr_mst_old", rd_data, 32'h8);
    check("clr_mst_irq", irq_en, 0);

    csr_req(2'd1, 12'h305, 32'h8000_0103, 0);
    check("mtvec_old", rd_data, 32'h1000);
    csr_req(2'd0, 12'h305, 32'h0, 0);
    check("mtvec_rd", rd_data, 32'h8000_0100);
    check("mtvec_o",  mtvec, 32'h8000_0100);

    csr_req(2'd1, 12'hF14, 32'h77, 0);
    check("hart_wr_ro",  rd_ro, 1);
    check("hart_wr_ill", rd_ill, 1);
    check("hart_wr_ex",  rd_exists, 1);
    check("hart_wr_old", rd_data, 32'h5);
    csr_req(2'd0, 12'hF14, 32'h0, 0);
    check("hart_rd",     rd_data, 32'h5);
    check("hart_rd_ill", rd_ill, 0);
    csr_req(2'd0, 12'h7FF, 32'h0, 0);
    check("unk_ex",   rd_exists, 0);
    check("unk_ill",  rd_ill, 1);
    check("unk_data", rd_data, 0);

    csr_req(2'd0, 12'h301, 32'h0, 0);
    check("misa", rd_data, 32'h4000_0100);
    irq_pending = 32'h0000_0A0A;
    csr_req(2'd1, 12'h344, 32'h0, 0);
    check("mip_wr_old", rd_data, 32'hA0A);
    check("mip_wr_ill", rd_ill, 0);
    csr_req(2'd0, 12'h344, 32'h0, 0);
    check("mip_rd", rd_data, 32'hA0A);
    csr_req(2'd1, 12'h304, 32'hFFFF_FFFF, 0);
    csr_req(2'd0, 12'h304, 32'h0, 0);
    check("mie_mask", rd_data, 32'h888);
    csr_req(2'd1, 12'h341, 32'h1235, 0);
    csr_req(2'd0, 12'h341, 32'h0, 0);
    check("mepc_wr", rd_data, 32'h1234);
    check("mepc_o_wr", mepc, 32'h1234);

    // Trap entry and return.
    csr_req(2'd2, 12'h300, 32'h8, 0);
    trap_pc = 32'h205; trap_cause = 32'h8000_0007; trap_val = 32'h1234_5678;
    pulse(1, 0);
    check("trap_mepc",  mepc, 32'h204);
    check("trap_irqen", irq_en, 0);
    csr_req(2'd0, 12'h342, 32'h0, 0);
    check("trap_mcause", rd_data, 32'h8000_0007);
    csr_req(2'd0, 12'h343, 32'h0, 0);
    check("trap_mtval", rd_data, 32'h1234_5678);
    csr_req(2'd0, 12'h300, 32'h0, 0);
    check("trap_mstatus", rd_data, 32'h80);
    pulse(0, 1);
    check("mret_irqen", irq_en, 1);
    csr_req(2'd0, 12'h300, 32'h0, 0);
    check("mret_mstatus", rd_data, 32'h88);

    trap_pc = 32'h301;
    csr_req(2'd2, 12'h300, 32'h8, 1);
    check("coinc_old", rd_data, 32'h88);
    check("coinc_irqen", irq_en, 0);
    check("coinc_mepc", mepc, 32'h300);
    csr_req(2'd0, 12'h300, 32'h0, 0);
    check("coinc_mstatus", rd_data, 32'h80);

    trap_pc = 32'h400;
    pulse(1, 1);
    check("trapmret_mepc", mepc, 32'h400);
    csr_req(2'd0, 12'h300, 32'h0, 0);
    check("trapmret_mst", rd_data, 32'h0);

    csr_req(2'd1, 12'h7C0, 32'h6, 0);
    check("tags_clr_p", tags_irq_clear, 1);
    check("tags_if",    tags_if_en, 1);
    check("tags_en",    tags_en, 0);
    @(posedge clk); #1;
    check("tags_clr_end", tags_irq_clear, 0);
    check("tags_if_hold", tags_if_en, 1);
    csr_req(2'd0, 12'h7C0, 32'h0, 0);
    check("tags_rd", rd_data, 32'h4);

    // csr_en held high through EXEC must not start a second access.
    csr_en = 1'b1; csr_op = 2'd1; csr_addr = 12'h340; csr_wdata = 32'h11;
    @(posedge clk); #1;
    csr_wdata = 32'h22;
    @(posedge clk); #1;
    csr_en = 1'b0;
    check("hold_done", csr_done, 1);
    @(posedge clk); #1;
    check("hold_done2", csr_done, 0);
    check("hold_busy2", csr_busy, 0);
    csr_req(2'd0, 12'h340, 32'h0, 0);
    check("hold_val", rd_data, 32'h11);

    csr_req(2'd1, 12'h340, 32'hA5A5_0000, 0);
    check("scr_old", rd_data, 32'h11);
    csr_req(2'd2, 12'h340, 32'h0000_00FF, 0);
    csr_req(2'd3, 12'h340, 32'hA500_0000, 0);
    check("scr_clr_old", rd_data, 32'hA5A5_00FF);
    csr_req(2'd0, 12'h340, 32'h0, 0);
    check("scr_final", rd_data, 32'h00A5_00FF);

`ifdef CSR_COUNTERS_EN
    csr_req(2'd0, 12'hB80, 32'h0, 0);
    check("mcycleh_0", rd_data, 0);
    csr_req(2'd1, 12'hB00, 32'hFFFF_FFFF, 0);
    csr_req(2'd0, 12'hB80, 32'h0, 0);
    check("mcycleh_inc", rd_data, 32'h1);
    csr_req(2'd0, 12'hB00, 32'h0, 0);
    check("mcycle_lo", rd_data, 32'h2);
    instret = 1'b1;
    repeat (3) @(posedge clk);
    #1 instret = 1'b0;
    csr_req(2'd0, 12'hB02, 32'h0, 0);
    check("minstret", rd_data, 32'h3);
`else
    instret = 1'b1;
    @(posedge clk); #1 instret = 1'b0;
    csr_req(2'd0, 12'hB00, 32'h0, 0);
    check("nocnt_ex",  rd_exists, 0);
    check("nocnt_ill", rd_ill, 1);
`endif

    // Reset pulse while the access is in EXEC drops it.
    csr_en = 1'b1; csr_op = 2'd1; csr_addr = 12'h340; csr_wdata = 32'hDEAD;
    @(posedge clk); #1;
    csr_en = 1'b0;
    check("rstx_busy1", csr_busy, 1);
    rst = 1'b1;
    #1;
    check("rstx_busy0", csr_busy, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rstx_done", csr_done, 0);
    check("rstx_mtvec", mtvec, 32'h1000);
    csr_req(2'd0, 12'h340, 32'h0, 0);
    check("rstx_scr", rd_data, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode CSR file for the CPU core, sitting beside the execute stage. It decodes CSR addresses, performs atomic read/write/set/clear operations through a busy/done handshake, and flags non-existent or read-only accesses. It also updates trap state (mepc/mcause/mtval/mstatus) on trap entry and mret, and drives the interrupt-enable, trap-vector and tag-control outputs.

## Interface
- CSR_DATA_WIDTH, 32, XLEN; legal values 32 or 64
- CSR_ADDR_WIDTH, 12, CSR address width
- HART_ID, 0, value returned by mhartid
- MISA_EXT, 'h100, misa extension bits [25:0]
- MTVEC_RESET, 0, mtvec reset value

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- csr_en_i  in  1  request strobe; sampled only when idle
- csr_op_i  in  2  0=READ, 1=WRITE, 2=SET, 3=CLEAR
- csr_addr_i  in  CSR_ADDR_WIDTH  CSR address
- csr_data_i  in  CSR_DATA_WIDTH  operand
- csr_data_o  out  CSR_DATA_WIDTH  old CSR value, valid while csr_done_o
- csr_busy_o  out  1  request in flight
- csr_done_o  out  1  one-cycle completion pulse
- csr_exists_o / csr_ro_o / csr_illegal_o  out  1 each  status of the completed access, valid with csr_done_o
- irq_pending_i  in  CSR_DATA_WIDTH  raw pending lines, reflected in mip
- instret_i  in  1  instruction-retired pulse
- trap_i, mret_i  in  1 each  trap entry / return pulses
- trap_pc_i, trap_cause_i, trap_val_i  in  CSR_DATA_WIDTH each  trap info
- irq_en_o, tags_en_o, tags_if_en_o, tags_irq_clear_o  out  1 each
- mtvec_o, mepc_o  out  CSR_DATA_WIDTH each

## Operation
- FSM: IDLE -> EXEC -> IDLE.
  - csr_en_i in IDLE latches op, address and data, then moves to EXEC.
  - csr_en_i in EXEC is ignored.
- EXEC does the following in one cycle:
  - reads the old value;
  - computes the new value: WRITE=d, SET=old|d, CLEAR=old&~d, READ=no write;
  - applies the per-register write mask;
  - registers the old value onto csr_data_o and the status flags;
  - returns to IDLE.
- Registers and addresses:
  - mvendorid F11 = 0.
  - mhartid F14 = HART_ID.
  - mstatus 300: only MIE[3] and MPIE[7] stored; other bits read 0.
  - misa 301: MXL = 1 (32-bit) or 2 (64-bit) in the top two bits, plus MISA_EXT; writes ignored.
  - mie 304: only bits 11, 7 and 3 are stored.
  - mtvec 305: bits [1:0] forced 0.
  - mscratch 340: full width.
  - mepc 341: bit 0 forced 0.
  - mcause 342, mtval 343: full width.
  - mip 344: reads irq_pending_i; writes ignored.
  - mtags 7C0: bit0 tags_en; bit2 tags_if_en (holds its own value); bit1 tags_irq_clear, which pulses one cycle on write and reads 0.
- Read-only: csr_addr_i[11:10]==2'b11. A non-READ op to a read-only address sets ro=1 and illegal=1, and no state changes.
- Unknown address: exists=0, illegal=1, data_o=0, and no state changes.
- trap_i:
  - mepc <= trap_pc_i & ~1;
  - mcause <= trap_cause_i;
  - mtval <= trap_val_i;
  - MPIE <= MIE, MIE <= 0.
- mret_i: MIE <= MPIE, MPIE <= 1.
- Priorities:
  - trap_i and mret_i in the same cycle: trap wins.
  - trap/mret and an EXEC write to the same register: trap/mret wins for the fields it touches.
  - EXEC writes to other registers proceed normally.
- irq_en_o = mstatus.MIE. mtvec_o and mepc_o are direct register outputs.

## Timing
- Request sampled at edge N. csr_busy_o=1 during cycle N+1.
- csr_done_o=1 and csr_data_o/status valid during cycle N+2. csr_busy_o=0 during cycle N+2.
- Write state is visible from cycle N+2 onward.
- Back-to-back: the next request may be presented in cycle N+2.
- Reset:
  - all outputs and state 0, except mtvec = MTVEC_RESET;
  - FSM -> IDLE;
  - a request in flight when reset asserts is dropped without a write.

## Configuration
- CSR_COUNTERS_EN defined: adds the following counters.
  - mcycle B00, incremented every cycle.
  - minstret B02, incremented on instret_i.
  - Both counters are 64-bit and wrap from all-ones to 0.
  - When CSR_DATA_WIDTH=32, mcycleh B80 and minstreth B82 expose bits [63:32].
  - A CSR write to a counter half takes precedence over that cycle's increment of that half.
  - The carry into the high half is suppressed when the high half is being written.
- CSR_COUNTERS_EN undefined: those addresses are non-existent, and instret_i is ignored.

## Structure
- csr_pkg holds:
  - CSR address constants;
  - op encoding;
  - internal register index enum;
  - mstatus bit positions;
  - per-register write masks;
  - the mtags address.
- Sub-module csr_counter64 (clk, async reset, inc, write-low, write-high, 64-bit value), instantiated twice under CSR_COUNTERS_EN.

## Test plan
- SET mstatus with 8 after reset: data_o=0 at N+2, irq_en_o=1 from N+2. Then CLEAR 8: data_o=8, irq_en_o=0.
- WRITE mtvec with 0x8000_0103: reads back 0x8000_0100, and mtvec_o matches.
- WRITE mhartid: ro=1, illegal=1, value unchanged. READ 0x7FF: exists=0, illegal=1, data_o=0.
- With MIE=1, pulse trap_i with pc 0x205, cause 0x8000_0007:
  - mepc=0x204, mcause matches, MIE=0, MPIE=1.
  - Then mret_i: MIE=1.
  - trap_i coincident with an EXEC SET of mstatus: trap result is kept.
- WRITE mtags with 6: tags_irq_clear_o pulses for one cycle, tags_if_en_o=1 and stays 1, tags_en_o=0. A READ of mtags then returns 4.
- With CSR_COUNTERS_EN and 32-bit width: WRITE mcycle 0xFFFF_FFFF, then after 2 cycles mcycleh has incremented by 1. Assert rst_i during EXEC: busy drops immediately and no write occurs.
